// File: rtl/sr_counter_pkg.sv
// Shared definitions for the shift-register sequence generator: mode codes,
// per-mode seed values and the maximal-length LFSR tap table.
package sr_counter_pkg;

   typedef enum logic [1:0] {
      RING    = 2'b00,
      JOHNSON = 2'b01,
      LFSR    = 2'b10,
      HOLD    = 2'b11
   } mode_e;

   localparam int SEED_RING    = 1;
   localparam int SEED_JOHNSON = 0;
   localparam int SEED_LFSR    = 1;

   function automatic int mode_seed(mode_e m);
      case (m)
         RING:    return SEED_RING;
         JOHNSON: return SEED_JOHNSON;
         LFSR:    return SEED_LFSR;
         default: return 0;
      endcase
   endfunction

   // Bit n-1 set for tap n; widths outside 3..8 are rejected where this is used.
   function automatic logic [7:0] lfsr_taps(int width);
      case (width)
         3:       return 8'b0000_0110;
         4:       return 8'b0000_1100;
         5:       return 8'b0001_0100;
         6:       return 8'b0011_0000;
         7:       return 8'b0110_0000;
         8:       return 8'b1011_1000;
         default: return 8'b0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/sr_counter_gen_if.sv
// Control and status bundle between a sequence-generator user (master) and
// the generator itself (slave).
interface sr_counter_gen_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             dir;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             wrap;

   modport master (
      output en, dir, mode, load, load_val,
      input  count, wrap
   );

   modport slave (
      input  en, dir, mode, load, load_val,
      output count, wrap
   );
endinterface

// File: rtl/sr_counter_next.sv
// Combinational step function: the shifted successor of the current state,
// whether that state is illegal for the mode, and whether the step lands on the seed.
module sr_counter_next
   import sr_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_count,
   input  mode_e            i_mode,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_next_count,
   output logic             o_is_illegal,
   output logic             o_hits_seed
);

   if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
      $error("sr_counter_next: WIDTH must lie in 3..8");
   end

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_seed;
   logic             w_legal;

   always_comb begin
      w_shift = i_count;
      w_legal = 1'b1;
      w_seed  = WIDTH'(mode_seed(i_mode));
      case (i_mode)
         RING: begin
            w_shift = i_dir ? {i_count[0], i_count[WIDTH-1:1]}
                            : {i_count[WIDTH-2:0], i_count[WIDTH-1]};
            w_legal = ($countones(i_count) == 1);
         end
         JOHNSON: begin
            w_shift = i_dir ? {~i_count[0], i_count[WIDTH-1:1]}
                            : {i_count[WIDTH-2:0], ~i_count[WIDTH-1]};
            // Legal Johnson states are low-filled or high-filled thermometer codes.
            w_legal = 1'b0;
            for (int k = 0; k <= WIDTH; k++) begin
               if (i_count == ({WIDTH{1'b1}} >> (WIDTH - k)) ||
                   i_count == ~({WIDTH{1'b1}} >> (WIDTH - k)))
                  w_legal = 1'b1;
            end
         end
         LFSR: begin
            w_shift = {i_count[WIDTH-2:0], ^(i_count & TAPS)};
            w_legal = |i_count;
         end
         default: begin
            w_shift = i_count;
            w_legal = 1'b1;
         end
      endcase
   end

   assign o_next_count = w_shift;
   assign o_is_illegal = ~w_legal;
   assign o_hits_seed  = (i_mode != HOLD) && w_legal && (w_shift == w_seed);

endmodule

// File: rtl/sr_counter_gen.sv
// WIDTH-bit ring / Johnson / LFSR sequence generator with load, hold and a
// registered pulse marking each normal return to the mode seed.
module sr_counter_gen
   import sr_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   sr_counter_gen_if.slave bus
);

   if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
      $error("sr_counter_gen: WIDTH must lie in 3..8");
   end

   localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(1);

   mode_e            w_mode;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_seed;
   logic             w_illegal;
   logic             w_hits_seed;
   logic             w_step;
   logic [WIDTH-1:0] r_count;
   logic             r_wrap;

   assign w_mode = mode_e'(bus.mode);
   assign w_seed = WIDTH'(mode_seed(w_mode));
   assign w_step = bus.en && (w_mode != HOLD);

   sr_counter_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .i_count     (r_count),
      .i_mode      (w_mode),
      .i_dir       (bus.dir),
      .o_next_count(w_next),
      .o_is_illegal(w_illegal),
      .o_hits_seed (w_hits_seed)
   );

   // An illegal state is replaced by the seed instead of shifted, and never flags wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= RESET_VAL;
         r_wrap  <= 1'b0;
      end else if (bus.load) begin
         r_count <= bus.load_val;
         r_wrap  <= 1'b0;
      end else if (w_step) begin
         r_count <= w_illegal ? w_seed : w_next;
         r_wrap  <= ~w_illegal && w_hits_seed;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign bus.count = r_count;
   assign bus.wrap  = r_wrap;

endmodule
